// File: rtl/id_ex_operand_stage_if.sv
// ID->EX operand stage bus: ID handshake, forwarding sources and
// registered ALU-side outputs.
interface id_ex_operand_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic              id_ready;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [XLEN-1:0]   id_rs1_data;
  logic [XLEN-1:0]   id_rs2_data;
  logic [XLEN-1:0]   id_imm;
  logic              id_alu_src;
  logic              id_uses_rs2;
  logic [3:0]        id_alu_ctrl;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              flush;
  logic              exmem_reg_write;
  logic [REG_AW-1:0] exmem_rd;
  logic [XLEN-1:0]   exmem_result;
  logic              memwb_reg_write;
  logic [REG_AW-1:0] memwb_rd;
  logic [XLEN-1:0]   memwb_result;
  logic              ex_ready;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_a;
  logic [XLEN-1:0]   ex_b;
  logic [XLEN-1:0]   ex_store_data;
  logic [3:0]        ex_alu_ctrl;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;

  modport master (
    output id_valid, id_rs1, id_rs2,
    output id_rs1_data, id_rs2_data,
    output id_imm, id_alu_src, id_uses_rs2,
    output id_alu_ctrl, id_rd,
    output id_reg_write, id_mem_read,
    output id_mem_write, flush,
    output exmem_reg_write, exmem_rd,
    output exmem_result,
    output memwb_reg_write, memwb_rd,
    output memwb_result, ex_ready,
    input  id_ready, ex_valid, ex_a, ex_b,
    input  ex_store_data, ex_alu_ctrl,
    input  ex_rd, ex_reg_write,
    input  ex_mem_read, ex_mem_write
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2,
    input  id_rs1_data, id_rs2_data,
    input  id_imm, id_alu_src, id_uses_rs2,
    input  id_alu_ctrl, id_rd,
    input  id_reg_write, id_mem_read,
    input  id_mem_write, flush,
    input  exmem_reg_write, exmem_rd,
    input  exmem_result,
    input  memwb_reg_write, memwb_rd,
    input  memwb_result, ex_ready,
    output id_ready, ex_valid, ex_a, ex_b,
    output ex_store_data, ex_alu_ctrl,
    output ex_rd, ex_reg_write,
    output ex_mem_read, ex_mem_write
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, immediate select
// and load-use hazard stall in front of the ALU.
module id_ex_operand_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input logic                  clk,
  input logic                  rst_n,
  id_ex_operand_stage_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [XLEN-1:0]   sd;
    logic [3:0]        ctrl;
    logic [REG_AW-1:0] rd;
    logic              rw;
    logic              mr;
    logic              mw;
  } id_ex_t;

  id_ex_t          ex_q;
  id_ex_t          ex_d;
  logic            ex_valid_q;
  logic            hz;
  logic            ready;
  logic            accept;
  logic [XLEN-1:0] fwd1;
  logic [XLEN-1:0] fwd2;

  assign hz = ex_valid_q & ex_q.mr & (ex_q.rd != '0)
            & ((ex_q.rd == bus.id_rs1)
            | (bus.id_uses_rs2 & (ex_q.rd == bus.id_rs2)));

  assign ready  = ~hz & (~ex_valid_q | bus.ex_ready);
  assign accept = bus.id_valid & ready & ~bus.flush;

  // EX/MEM wins over MEM/WB; x0 never forwards
  always_comb begin
    fwd1 = bus.id_rs1_data;
    if (bus.exmem_reg_write && bus.exmem_rd != '0
        && bus.exmem_rd == bus.id_rs1)
      fwd1 = bus.exmem_result;
    else if (bus.memwb_reg_write && bus.memwb_rd != '0
        && bus.memwb_rd == bus.id_rs1)
      fwd1 = bus.memwb_result;
  end

  always_comb begin
    fwd2 = bus.id_rs2_data;
    if (bus.exmem_reg_write && bus.exmem_rd != '0
        && bus.exmem_rd == bus.id_rs2)
      fwd2 = bus.exmem_result;
    else if (bus.memwb_reg_write && bus.memwb_rd != '0
        && bus.memwb_rd == bus.id_rs2)
      fwd2 = bus.memwb_result;
  end

  always_comb begin
    ex_d      = '0;
    ex_d.a    = fwd1;
    ex_d.b    = bus.id_alu_src ? bus.id_imm : fwd2;
    ex_d.sd   = fwd2;
    ex_d.ctrl = bus.id_alu_ctrl;
    ex_d.rd   = bus.id_rd;
    ex_d.rw   = bus.id_reg_write;
    ex_d.mr   = bus.id_mem_read;
    ex_d.mw   = bus.id_mem_write;
  end

  // flush beats hold; a bubble clears only valid and control bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
    end else if (accept) begin
      ex_valid_q <= 1'b1;
      ex_q       <= ex_d;
    end else if (bus.flush | ~ex_valid_q | bus.ex_ready) begin
      ex_valid_q <= 1'b0;
      ex_q.rw    <= 1'b0;
      ex_q.mr    <= 1'b0;
      ex_q.mw    <= 1'b0;
    end
  end

  assign bus.id_ready      = ready;
  assign bus.ex_valid      = ex_valid_q;
  assign bus.ex_a          = ex_q.a;
  assign bus.ex_b          = ex_q.b;
  assign bus.ex_store_data = ex_q.sd;
  assign bus.ex_alu_ctrl   = ex_q.ctrl;
  assign bus.ex_rd         = ex_q.rd;
  assign bus.ex_reg_write  = ex_q.rw;
  assign bus.ex_mem_read   = ex_q.mr;
  assign bus.ex_mem_write  = ex_q.mw;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed scoreboard bench for id_ex_operand_stage.
// Expected EX records are queued at accept and popped at capture.
module tb_id_ex_operand_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  id_ex_operand_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

  id_ex_operand_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  exp_t e;
  bit   cur_v;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".v"}, 32'(bus.ex_valid), 0);
    chk({tag, ".a"}, bus.ex_a, 0);
    chk({tag, ".b"}, bus.ex_b, 0);
    chk({tag, ".sd"}, bus.ex_store_data, 0);
    chk({tag, ".ctrl"}, 32'(bus.ex_alu_ctrl), 0);
    chk({tag, ".rd"}, 32'(bus.ex_rd), 0);
    chk({tag, ".rw"}, 32'(bus.ex_reg_write), 0);
    chk({tag, ".mr"}, 32'(bus.ex_mem_read), 0);
    chk({tag, ".mw"}, 32'(bus.ex_mem_write), 0);
  endtask

  task automatic chk_out(input string tag);
    chk({tag, ".v"}, 32'(bus.ex_valid), 32'(cur_v));
    if (cur_v) begin
      chk({tag, ".a"}, bus.ex_a, cur.a);
      chk({tag, ".b"}, bus.ex_b, cur.b);
      chk({tag, ".sd"}, bus.ex_store_data, cur.sd);
      chk({tag, ".ctrl"}, 32'(bus.ex_alu_ctrl), 32'(cur.ctrl));
      chk({tag, ".rd"}, 32'(bus.ex_rd), 32'(cur.rd));
    end
    chk({tag, ".rw"}, 32'(bus.ex_reg_write), 32'(cur.rw));
    chk({tag, ".mr"}, 32'(bus.ex_mem_read), 32'(cur.mr));
    chk({tag, ".mw"}, 32'(bus.ex_mem_write), 32'(cur.mw));
  endtask

  task automatic ins(input logic [4:0] rs1, input logic [31:0] d1,
                     input logic [4:0] rs2, input logic [31:0] d2,
                     input logic [31:0] imm, input bit src,
                     input bit u2, input logic [3:0] ctrl,
                     input logic [4:0] rd, input bit rw,
                     input bit mr, input bit mw);
    bus.id_valid     = 1'b1;
    bus.id_rs1       = rs1;
    bus.id_rs1_data  = d1;
    bus.id_rs2       = rs2;
    bus.id_rs2_data  = d2;
    bus.id_imm       = imm;
    bus.id_alu_src   = src;
    bus.id_uses_rs2  = u2;
    bus.id_alu_ctrl  = ctrl;
    bus.id_rd        = rd;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    bus.id_mem_write = mw;
  endtask

  task automatic fwd(input bit emw, input logic [4:0] emrd,
                     input logic [31:0] emres, input bit wbw,
                     input logic [4:0] wbrd, input logic [31:0] wbres);
    bus.exmem_reg_write = emw;
    bus.exmem_rd        = emrd;
    bus.exmem_result    = emres;
    bus.memwb_reg_write = wbw;
    bus.memwb_rd        = wbrd;
    bus.memwb_result    = wbres;
  endtask

  task automatic ex(input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] sd);
    e.a    = a;
    e.b    = b;
    e.sd   = sd;
    e.ctrl = bus.id_alu_ctrl;
    e.rd   = bus.id_rd;
    e.rw   = bus.id_reg_write;
    e.mr   = bus.id_mem_read;
    e.mw   = bus.id_mem_write;
  endtask

  task automatic cycle(input bit exp_rdy, input string tag);
    bit acc;
    bit fl;
    bit rdy;
    #1;
    chk({tag, ".rdy"}, 32'(bus.id_ready), 32'(exp_rdy));
    acc = bus.id_valid & exp_rdy & ~bus.flush;
    fl  = bus.flush;
    rdy = bus.ex_ready;
    if (acc) q.push_back(e);
    @(posedge clk);
    #1;
    if (acc) begin
      cur   = q.pop_front();
      cur_v = 1'b1;
    end else if (fl || !cur_v || rdy) begin
      cur_v  = 1'b0;
      cur.rw = 1'b0;
      cur.mr = 1'b0;
      cur.mw = 1'b0;
    end
    chk_out(tag);
  endtask

  initial begin
    cur   = '{default: '0};
    e     = '{default: '0};
    cur_v = 1'b0;
    ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.id_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.ex_ready = 1'b1;
    fwd(0, 0, 0, 0, 0, 0);

    #1 rst_n = 1'b0;
    #1;
    chk_zero("rst");
    chk("rst.rdy", 32'(bus.id_ready), 1);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    ins(1, 5, 2, 7, 0, 0, 1, 4'b0010, 3, 1, 0, 0);
    ex(5, 7, 7);
    cycle(1, "add");

    ins(3, 'h99, 4, 1, 0, 0, 1, 4'b0000, 8, 1, 0, 0);
    fwd(1, 3, 'h10, 1, 3, 'h20);
    ex('h10, 1, 1);
    cycle(1, "fwd_em");

    fwd(0, 3, 'h10, 1, 3, 'h20);
    ex('h20, 1, 1);
    cycle(1, "fwd_wb");

    ins(0, 'h55, 4, 1, 0, 0, 1, 4'b1111, 8, 1, 0, 0);
    fwd(1, 0, 'h10, 1, 0, 'h20);
    ex('h55, 1, 1);
    cycle(1, "fwd_x0");

    ins(8, 'h100, 7, 1, 'hFFFF_FFFC, 1, 1, 4'b0010, 0, 0, 0, 1);
    fwd(1, 7, 9, 0, 0, 0);
    ex('h100, 'hFFFF_FFFC, 9);
    cycle(1, "imm");

    ins(1, 'h200, 0, 0, 4, 1, 0, 4'b0010, 5, 1, 1, 0);
    fwd(0, 0, 0, 0, 0, 0);
    ex('h200, 4, 0);
    cycle(1, "lw5");

    ins(5, 'hdead, 1, 3, 0, 0, 1, 4'b0010, 6, 1, 0, 0);
    cycle(0, "lu_stall");
    fwd(1, 5, 'h77, 0, 0, 0);
    ex('h77, 3, 3);
    cycle(1, "lu_go");

    ins(2, 'h300, 0, 0, 8, 1, 0, 4'b0010, 9, 1, 1, 0);
    fwd(0, 0, 0, 0, 0, 0);
    ex('h300, 8, 0);
    cycle(1, "lw9");

    ins(2, 1, 9, 'hbad, 'h10, 1, 0, 4'b0001, 10, 1, 0, 0);
    ex(1, 'h10, 'hbad);
    cycle(1, "rs2_nouse");

    ins(2, 'h300, 0, 0, 8, 1, 0, 4'b0010, 9, 1, 1, 0);
    ex('h300, 8, 0);
    cycle(1, "lw9b");

    ins(1, 4, 9, 'hbad, 0, 0, 1, 4'b0110, 11, 1, 0, 0);
    cycle(0, "rs2_stall");
    fwd(1, 9, 'h30, 0, 0, 0);
    ex(4, 'h30, 'h30);
    cycle(1, "rs2_go");

    ins(1, 1, 0, 0, 0, 1, 0, 4'b0010, 0, 1, 1, 0);
    fwd(0, 0, 0, 0, 0, 0);
    ex(1, 0, 0);
    cycle(1, "lw_x0");

    ins(0, 0, 0, 0, 0, 0, 1, 4'b0010, 12, 1, 0, 0);
    ex(0, 0, 0);
    cycle(1, "x0_nohz");

    ins(1, 'h11, 2, 'h22, 0, 0, 1, 4'b0001, 13, 1, 0, 0);
    ex('h11, 'h22, 'h22);
    cycle(1, "bp_cap");

    bus.ex_ready = 1'b0;
    ins(3, 'h33, 4, 'h44, 0, 0, 1, 4'b0010, 14, 1, 0, 0);
    fwd(1, 1, 'hee, 0, 0, 0);
    cycle(0, "bp_hold");
    bus.flush = 1'b1;
    cycle(0, "bp_flush");
    bus.flush    = 1'b0;
    bus.id_valid = 1'b0;
    cycle(1, "bp_after");
    bus.ex_ready = 1'b1;
    fwd(0, 0, 0, 0, 0, 0);
    cycle(1, "idle");

    ins(1, 'h200, 0, 0, 4, 1, 0, 4'b0010, 5, 1, 1, 0);
    ex('h200, 4, 0);
    cycle(1, "rs_lw");
    bus.ex_ready = 1'b0;
    ins(5, 'hdead, 1, 3, 0, 0, 1, 4'b0010, 6, 1, 0, 0);
    cycle(0, "rs_stall");

    #2 rst_n = 1'b0;
    cur   = '{default: '0};
    cur_v = 1'b0;
    q.delete();
    #1;
    chk_zero("arst");
    chk("arst.rdy", 32'(bus.id_ready), 1);
    bus.id_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_out("arst_idle");

    bus.ex_ready = 1'b1;
    ins(5, 'hdead, 1, 3, 0, 0, 1, 4'b0010, 6, 1, 0, 0);
    fwd(1, 5, 'h99, 0, 0, 0);
    ex('h99, 3, 3);
    cycle(1, "post_rst");

    chk("sb_empty", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
